// File: rtl/retire_stage.sv
// retire_stage: in-order commit of the ROB head (tag free, AMT write, stores, mispredict flush, halt).
// Optional macro RETIRE_STATS_EN adds a free-running 64-bit commit counter on retire_count.
module retire_stage #(
  parameter int XLEN   = 32,
  parameter int PREG_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              retire_en,
  input  logic [PREG_W:0]   retire_t,
  input  logic [PREG_W:0]   retire_t_old,
  input  logic              halt,
  input  logic              wr_mem,
  input  logic [4:0]        dest_reg_idx,
  input  logic [XLEN-1:0]   NPC,
  input  logic [XLEN-1:0]   result,
  input  logic [XLEN-1:0]   rs2_value,
  input  logic              take_branch,
  input  logic [1:0]        mem_size,
  output logic              ir_stall,
  output logic              free_en,
  output logic [PREG_W:0]   free_t,
  output logic              amt_wr_en,
  output logic [4:0]        amt_idx,
  output logic [PREG_W:0]   amt_t,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_data,
  output logic [1:0]        mem_size_out,
  output logic              flush_en,
  output logic [XLEN-1:0]   flush_pc,
  output logic              halted,
  output logic [63:0]       retire_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    HALTED  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              commit_s;
  logic              buf_load_s;
  logic [XLEN-1:0]   buf_addr_r;
  logic [XLEN-1:0]   buf_data_r;
  logic [1:0]        buf_size_r;

  // The head's next-PC is not needed to commit; fold it away explicitly.
  logic unused_s;
  assign unused_s = ^NPC;

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Store buffer: captured when the head store is accepted from IDLE
  always_ff @(posedge clock) begin
    if (reset) begin
      buf_addr_r <= {XLEN{1'b0}};
      buf_data_r <= {XLEN{1'b0}};
      buf_size_r <= 2'b00;
    end else if (buf_load_s) begin
      buf_addr_r <= result;
      buf_data_r <= rs2_value;
      buf_size_r <= mem_size;
    end
  end

  // Next state, stall/handshake controls and commit decision
  always_comb begin
    state_s       = state_r;
    commit_s      = 1'b0;
    buf_load_s    = 1'b0;
    ir_stall      = 1'b0;
    mem_req_valid = 1'b0;
    halted        = 1'b0;
    if (reset) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (retire_en && halt) begin
            ir_stall = 1'b1;
            state_s  = HALTED;
          end else if (retire_en && wr_mem) begin
            ir_stall   = 1'b1;
            buf_load_s = 1'b1;
            state_s    = ST_REQ;
          end else if (retire_en) begin
            commit_s = 1'b1;
          end else begin
            commit_s = 1'b0;
          end
        end
        ST_REQ: begin
          ir_stall      = 1'b1;
          mem_req_valid = 1'b1;
          if (mem_req_ready) state_s = ST_DONE;
          else               state_s = ST_REQ;
        end
        ST_DONE: begin
          commit_s = 1'b1;
          state_s  = IDLE;
        end
        HALTED: begin
          ir_stall = 1'b1;
          halted   = 1'b1;
          state_s  = HALTED;
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // Commit-side and memory-request datapath outputs
  always_comb begin
    free_en      = 1'b0;
    free_t       = {(PREG_W+1){1'b0}};
    amt_wr_en    = 1'b0;
    amt_idx      = 5'd0;
    amt_t        = {(PREG_W+1){1'b0}};
    flush_en     = 1'b0;
    flush_pc     = {XLEN{1'b0}};
    mem_addr     = {XLEN{1'b0}};
    mem_data     = {XLEN{1'b0}};
    mem_size_out = 2'b00;
    if (commit_s) begin
      free_en   = retire_t_old[PREG_W];
      free_t    = retire_t_old;
      amt_wr_en = retire_t[PREG_W] && (dest_reg_idx != 5'd0);
      amt_idx   = dest_reg_idx;
      amt_t     = retire_t;
      flush_en  = take_branch;
      flush_pc  = result;
    end else begin
      free_en = 1'b0;
    end
    if (mem_req_valid) begin
      mem_addr     = buf_addr_r;
      mem_data     = buf_data_r;
      mem_size_out = buf_size_r;
    end else begin
      mem_size_out = 2'b00;
    end
  end

`ifdef RETIRE_STATS_EN
  logic [63:0] count_r;

  // Free-running commit counter
  always_ff @(posedge clock) begin
    if (reset)         count_r <= 64'd0;
    else if (commit_s) count_r <= count_r + 64'd1;
  end

  assign retire_count = reset ? 64'd0 : count_r;
`else
  assign retire_count = 64'd0;
`endif

endmodule

// File: tb/tb_retire_stage.sv
// tb_retire_stage: directed test-plan scenarios plus randomized traffic, checked every cycle
// against a transaction-level model of the retire rules.
module tb_retire_stage;
  localparam int XLEN   = 32;
  localparam int PREG_W = 6;

  logic              clock = 1'b0;
  logic              reset;
  logic              retire_en;
  logic [PREG_W:0]   retire_t;
  logic [PREG_W:0]   retire_t_old;
  logic              halt;
  logic              wr_mem;
  logic [4:0]        dest_reg_idx;
  logic [XLEN-1:0]   NPC;
  logic [XLEN-1:0]   result;
  logic [XLEN-1:0]   rs2_value;
  logic              take_branch;
  logic [1:0]        mem_size;
  logic              ir_stall;
  logic              free_en;
  logic [PREG_W:0]   free_t;
  logic              amt_wr_en;
  logic [4:0]        amt_idx;
  logic [PREG_W:0]   amt_t;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_data;
  logic [1:0]        mem_size_out;
  logic              flush_en;
  logic [XLEN-1:0]   flush_pc;
  logic              halted;
  logic [63:0]       retire_count;

  int passes = 0;
  int total  = 0;

  retire_stage #(.XLEN(XLEN), .PREG_W(PREG_W)) dut (
    .clock(clock), .reset(reset), .retire_en(retire_en), .retire_t(retire_t),
    .retire_t_old(retire_t_old), .halt(halt), .wr_mem(wr_mem), .dest_reg_idx(dest_reg_idx),
    .NPC(NPC), .result(result), .rs2_value(rs2_value), .take_branch(take_branch),
    .mem_size(mem_size), .ir_stall(ir_stall), .free_en(free_en), .free_t(free_t),
    .amt_wr_en(amt_wr_en), .amt_idx(amt_idx), .amt_t(amt_t), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_size_out(mem_size_out), .flush_en(flush_en), .flush_pc(flush_pc),
    .halted(halted), .retire_count(retire_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model state: what has been committed to so far, expressed as pending work
  logic              m_halted       = 1'b0;
  logic              m_store_wait   = 1'b0;
  logic              m_store_commit = 1'b0;
  logic [XLEN-1:0]   m_addr         = '0;
  logic [XLEN-1:0]   m_data         = '0;
  logic [1:0]        m_size         = '0;
  logic [63:0]       m_count        = '0;

  always @(negedge clock) begin : model
    logic commit;
    logic e_stall, e_mv, e_free, e_amt, e_flush, e_halted;
    logic [XLEN-1:0] e_addr, e_data, e_fpc;
    logic [1:0] e_size;
    logic [PREG_W:0] e_free_t, e_amt_t;
    logic [4:0] e_idx;
    logic [63:0] e_count;
    commit = 1'b0; e_stall = 1'b0; e_mv = 1'b0; e_free = 1'b0; e_amt = 1'b0;
    e_flush = 1'b0; e_halted = 1'b0; e_addr = '0; e_data = '0; e_fpc = '0; e_size = '0;
    e_free_t = '0; e_amt_t = '0; e_idx = '0;
    if (reset) begin
      commit = 1'b0;
    end else if (m_halted) begin
      e_stall = 1'b1; e_halted = 1'b1;
    end else if (m_store_wait) begin
      e_stall = 1'b1; e_mv = 1'b1; e_addr = m_addr; e_data = m_data; e_size = m_size;
    end else if (m_store_commit) begin
      commit = 1'b1;
    end else if (retire_en) begin
      if (halt || wr_mem) e_stall = 1'b1;
      else commit = 1'b1;
    end
    if (commit) begin
      e_free = retire_t_old[PREG_W]; e_free_t = retire_t_old;
      e_amt = retire_t[PREG_W] && dest_reg_idx != 5'd0; e_idx = dest_reg_idx; e_amt_t = retire_t;
      e_flush = take_branch; e_fpc = result;
    end
`ifdef RETIRE_STATS_EN
    e_count = reset ? 64'd0 : m_count;
`else
    e_count = 64'd0;
`endif
    chk("m_ir_stall", 64'(ir_stall), 64'(e_stall));
    chk("m_free_en", 64'(free_en), 64'(e_free));
    chk("m_free_t", 64'(free_t), 64'(e_free_t));
    chk("m_amt_wr_en", 64'(amt_wr_en), 64'(e_amt));
    chk("m_amt_idx", 64'(amt_idx), 64'(e_idx));
    chk("m_amt_t", 64'(amt_t), 64'(e_amt_t));
    chk("m_mem_req_valid", 64'(mem_req_valid), 64'(e_mv));
    chk("m_mem_addr", 64'(mem_addr), 64'(e_addr));
    chk("m_mem_data", 64'(mem_data), 64'(e_data));
    chk("m_mem_size", 64'(mem_size_out), 64'(e_size));
    chk("m_flush_en", 64'(flush_en), 64'(e_flush));
    chk("m_flush_pc", 64'(flush_pc), 64'(e_fpc));
    chk("m_halted", 64'(halted), 64'(e_halted));
    chk("m_retire_count", retire_count, e_count);
    // Advance to what the next cycle must look like
    if (reset) begin
      m_halted <= 1'b0; m_store_wait <= 1'b0; m_store_commit <= 1'b0;
      m_addr <= '0; m_data <= '0; m_size <= '0; m_count <= 64'd0;
    end else begin
      if (m_halted) begin
        m_halted <= 1'b1;
      end else if (m_store_wait) begin
        if (mem_req_ready) begin m_store_wait <= 1'b0; m_store_commit <= 1'b1; end
      end else if (m_store_commit) begin
        m_store_commit <= 1'b0;
      end else if (retire_en && halt) begin
        m_halted <= 1'b1;
      end else if (retire_en && wr_mem) begin
        m_store_wait <= 1'b1; m_addr <= result; m_data <= rs2_value; m_size <= mem_size;
      end
      if (commit) m_count <= m_count + 64'd1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    retire_en = 1'b0; retire_t = '0; retire_t_old = '0; halt = 1'b0; wr_mem = 1'b0;
    dest_reg_idx = '0; NPC = '0; result = '0; rs2_value = '0; take_branch = 1'b0;
    mem_size = '0; mem_req_ready = 1'b0;
  endtask

  task automatic rand_fields();
    retire_t = 7'($urandom); retire_t_old = 7'($urandom); dest_reg_idx = 5'($urandom);
    NPC = $urandom; result = $urandom; rs2_value = $urandom; take_branch = 1'($urandom);
    mem_size = 2'($urandom); mem_req_ready = 1'($urandom);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    tick(); tick();
    reset = 1'b0;
    // ALU retire
    retire_en = 1'b1; retire_t = 7'h45; retire_t_old = 7'h4C; dest_reg_idx = 5'd3;
    @(negedge clock);
    chk("alu_stall", 64'(ir_stall), 64'd0);
    chk("alu_free_en", 64'(free_en), 64'd1);
    chk("alu_free_t", 64'(free_t), 64'h4C);
    chk("alu_amt_en", 64'(amt_wr_en), 64'd1);
    chk("alu_amt_idx", 64'(amt_idx), 64'd3);
    chk("alu_amt_t", 64'(amt_t), 64'h45);
    // x0 destination
    tick();
    retire_t = 7'h47; retire_t_old = 7'h00; dest_reg_idx = 5'd0;
    @(negedge clock);
    chk("x0_amt_en", 64'(amt_wr_en), 64'd0);
    chk("x0_free_en", 64'(free_en), 64'd0);
    chk("x0_stall", 64'(ir_stall), 64'd0);
    // Store with ready withheld three cycles
    tick();
    wr_mem = 1'b1; result = 32'h100; rs2_value = 32'hDEAD; mem_size = 2'b10;
    retire_t = 7'h00; retire_t_old = 7'h4A;
    @(negedge clock);
    chk("st_accept_stall", 64'(ir_stall), 64'd1);
    chk("st_accept_valid", 64'(mem_req_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      mem_req_ready = (i == 3);
      @(negedge clock);
      chk("st_req_valid", 64'(mem_req_valid), 64'd1);
      chk("st_req_addr", 64'(mem_addr), 64'h100);
      chk("st_req_data", 64'(mem_data), 64'hDEAD);
      chk("st_req_size", 64'(mem_size_out), 64'd2);
      chk("st_req_stall", 64'(ir_stall), 64'd1);
    end
    tick();
    mem_req_ready = 1'b0;
    @(negedge clock);
    chk("st_done_stall", 64'(ir_stall), 64'd0);
    chk("st_done_valid", 64'(mem_req_valid), 64'd0);
    chk("st_done_free_t", 64'(free_t), 64'h4A);
    chk("st_done_amt_en", 64'(amt_wr_en), 64'd0);
    tick();
    idle_inputs();
    @(negedge clock);
`ifdef RETIRE_STATS_EN
    chk("st_count", retire_count, 64'd3);
`else
    chk("st_count", retire_count, 64'd0);
`endif
    // Mispredict
    tick();
    retire_en = 1'b1; take_branch = 1'b1; result = 32'h2040;
    @(negedge clock);
    chk("br_flush_en", 64'(flush_en), 64'd1);
    chk("br_flush_pc", 64'(flush_pc), 64'h2040);
    chk("br_stall", 64'(ir_stall), 64'd0);
    tick();
    idle_inputs();
    @(negedge clock);
    chk("br_flush_drop", 64'(flush_en), 64'd0);
    // Randomized traffic with occasional resets
    repeat (400) begin
      tick();
      rand_fields();
      retire_en = 1'($urandom);
      wr_mem = ($urandom_range(3) == 0);
      halt = 1'b0;
      reset = ($urandom_range(49) == 0);
    end
    tick();
    reset = 1'b1; idle_inputs();
    tick();
    reset = 1'b0;
    // Halt, then keep offering retires
    retire_en = 1'b1; halt = 1'b1;
    @(negedge clock);
    chk("halt_stall", 64'(ir_stall), 64'd1);
    chk("halt_not_yet", 64'(halted), 64'd0);
    repeat (10) begin
      tick();
      rand_fields();
      wr_mem = 1'($urandom); halt = 1'($urandom);
      @(negedge clock);
      chk("hlt_halted", 64'(halted), 64'd1);
      chk("hlt_stall", 64'(ir_stall), 64'd1);
      chk("hlt_activity", 64'({free_en, amt_wr_en, mem_req_valid, flush_en}), 64'd0);
    end
    // Reset during an outstanding store request
    tick();
    reset = 1'b1; idle_inputs();
    tick();
    reset = 1'b0; retire_en = 1'b1; wr_mem = 1'b1; result = 32'h300; rs2_value = 32'h55;
    tick();
    @(negedge clock);
    chk("rst_st_pre_valid", 64'(mem_req_valid), 64'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; idle_inputs();
    @(negedge clock);
    chk("rst_st_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_st_stall", 64'(ir_stall), 64'd0);
    chk("rst_st_halted", 64'(halted), 64'd0);
    chk("rst_st_count", retire_count, 64'd0);
    tick();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
